// File: rtl/amba3_axi_slave_mem_pkg.sv
// Shared AXI3 types and the burst next-address rule used by the slave memory.
package pkg_amba3;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;

  localparam int ADDR_MAX = 64;

  // Reserved burst encoding 2'b11 falls through to the INCR behaviour.
  function automatic logic [ADDR_MAX-1:0] next_burst_addr(
    input logic [ADDR_MAX-1:0] addr,
    input logic [3:0]          len,
    input logic [2:0]          size,
    input logic [1:0]          burst
  );
    logic [ADDR_MAX-1:0] step;
    logic [ADDR_MAX-1:0] nxt;
    logic [ADDR_MAX-1:0] win_mask;
    step     = 64'd1 << size;
    nxt      = (addr & ~(step - 64'd1)) + step;
    win_mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst_e'(burst))
      FIXED:   return addr;
      WRAP:    return (addr & ~win_mask) | (nxt & win_mask);
      default: return nxt;
    endcase
  endfunction

endpackage

// File: rtl/amba3_axi_slave_mem_burst_addr.sv
// Combinational next beat address for one AXI burst channel.
module amba3_axi_burst_addr
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE = 32
) (
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [3:0]           len,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [ADDR_SIZE-1:0] next_addr
);

  assign next_addr = ADDR_SIZE'(next_burst_addr(ADDR_MAX'(addr), len, size, burst));

endmodule

// File: rtl/amba3_axi_slave_mem.sv
// AXI3 slave backed by a word-wide memory, one outstanding write and one read.
// Define AMBA3_AXI_SLAVE_MEM_SLVERR_EN to reject beats beyond MEM_DEPTH with SLVERR.
module amba3_axi_slave_mem
  import pkg_amba3::*;
#(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128,
  parameter int MEM_DEPTH = 256
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TXID_SIZE-1:0]   awid,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [3:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [TXID_SIZE-1:0]   wid,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [TXID_SIZE-1:0]   bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [TXID_SIZE-1:0]   arid,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [3:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [TXID_SIZE-1:0]   rid,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int BYTE_BITS = $clog2(STRB_SIZE);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
`ifdef AMBA3_AXI_SLAVE_MEM_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'(BYTE_BITS)) ? 3'(BYTE_BITS) : size;
  endfunction

  function automatic logic beyond_depth(input logic [ADDR_SIZE-1:0] a);
    return SLVERR_EN && ((a >> (BYTE_BITS + IDX_BITS)) != '0);
  endfunction

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  w_state_e             w_state;
  logic [ADDR_SIZE-1:0] w_addr, w_next;
  logic [3:0]           aw_len, w_cnt;
  logic [2:0]           aw_size;
  logic [1:0]           aw_burst;
  logic                 w_err, w_fire, w_beat_err;

  r_state_e             r_state;
  logic [ADDR_SIZE-1:0] r_addr, r_next;
  logic [3:0]           ar_len, r_cnt;
  logic [2:0]           ar_size;
  logic [1:0]           ar_burst;
  logic                 ar_err, rn_err;
  logic [DATA_SIZE-1:0] ar_word, rn_word;

  logic unused_w;
  assign unused_w = ^{wid, wlast};

  amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_wr_addr (
    .addr(w_addr), .len(aw_len), .size(aw_size), .burst(aw_burst), .next_addr(w_next)
  );

  amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_rd_addr (
    .addr(r_addr), .len(ar_len), .size(ar_size), .burst(ar_burst), .next_addr(r_next)
  );

  assign w_fire     = wvalid && wready;
  assign w_beat_err = beyond_depth(w_addr);
  assign ar_err     = beyond_depth(araddr);
  assign rn_err     = beyond_depth(r_next);
  assign ar_word    = ar_err ? '0 : mem[araddr[BYTE_BITS +: IDX_BITS]];
  assign rn_word    = rn_err ? '0 : mem[r_next[BYTE_BITS +: IDX_BITS]];

  // Memory has no reset; reads elsewhere sample it before this edge commits.
  always_ff @(posedge aclk) begin
    if (w_fire && !w_beat_err) begin
      for (int i = 0; i < STRB_SIZE; i++) begin
        if (wstrb[i]) mem[w_addr[BYTE_BITS +: IDX_BITS]][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state  <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
      w_addr   <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            bid      <= awid;
            w_addr   <= awaddr;
            aw_len   <= awlen;
            aw_size  <= clamp_size(awsize);
            aw_burst <= awburst;
            w_cnt    <= '0;
            w_err    <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b1;
            w_state  <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        // Beat count, not wlast, decides where the burst ends.
        W_DATA: begin
          if (w_fire) begin
            w_err <= w_err | w_beat_err;
            if (w_cnt == aw_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_err) ? SLVERR : OKAY;
              w_state <= W_RESP;
            end else begin
              w_addr <= w_next;
              w_cnt  <= w_cnt + 4'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
      r_addr   <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rid      <= arid;
            r_addr   <= araddr;
            ar_len   <= arlen;
            ar_size  <= clamp_size(arsize);
            ar_burst <= arburst;
            r_cnt    <= '0;
            rdata    <= ar_word;
            rresp    <= ar_err ? SLVERR : OKAY;
            rlast    <= (arlen == 4'd0);
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            r_state  <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_cnt  <= r_cnt + 4'd1;
              rdata  <= rn_word;
              rresp  <= rn_err ? SLVERR : OKAY;
              rlast  <= (r_cnt + 4'd1 == ar_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amba3_axi_slave_mem.sv
// Directed bench for amba3_axi_slave_mem with hand-computed memory images.
module tb_amba3_axi_slave_mem;
  import pkg_amba3::*;

  localparam int TXID = 4;
  localparam int AW   = 32;
  localparam int DW   = 128;

  logic            aclk = 1'b0;
  logic            areset;
  logic [TXID-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [3:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;

  amba3_axi_slave_mem #(.TXID_SIZE(TXID), .ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_DEPTH(256)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int            checks = 0;
  int            passes = 0;
  bit            rand_rready = 1'b0;
  logic [DW-1:0] wd [16];
  logic [DW/8-1:0] ws [16];
  logic [DW-1:0] rexp [16];

  localparam logic [DW-1:0] P0   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [DW-1:0] P1   = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
  localparam logic [DW-1:0] W10  = 128'h0000A395_00007163_00004739_03020100;
  localparam logic [DW-1:0] W11  = 128'h1f1e1d1c_1b1a1918_17161514_00001507;
  localparam logic [DW-1:0] W10F = 128'h0000A395_00007163_00394739_03020100;
  localparam logic [DW-1:0] WW   = 128'hC0DE0002_C0DE0001_C0DE0000_C0DE0003;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [1:0] exp_resp,
                            input int bstall);
    int n;
    bit tmo = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    tmo |= (n >= 50);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wid = id; wdata = wd[b]; wstrb = ws[b]; wlast = (b == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      tmo |= (n >= 50);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    tmo |= (n >= 50);
    for (int s = 0; s < bstall; s++) begin
      checkOutput($sformatf("b_stall_valid[%0d]", s), bvalid, 1'b1);
      checkOutput($sformatf("b_stall_id[%0d]", s), bid, id);
      checkOutput($sformatf("b_stall_resp[%0d]", s), bresp, exp_resp);
      checkOutput($sformatf("aw_blocked[%0d]", s), awready, 1'b0);
      @(negedge aclk);
    end
    checkOutput("bvalid", bvalid, 1'b1);
    checkOutput("bid", bid, id);
    checkOutput("bresp", bresp, exp_resp);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checkOutput("b_done", bvalid, 1'b0);
    checkOutput("awready_after_b", awready, 1'b1);
    checkOutput("wr_timeout", tmo, 1'b0);
  endtask

  task automatic applyRead(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [1:0] exp_resp);
    int n;
    int beat;
    bit tmo = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    tmo |= (n >= 50);
    @(negedge aclk);
    arvalid = 1'b0;
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 200) begin
      checkOutput($sformatf("rvalid[%0d]", beat), rvalid, 1'b1);
      checkOutput($sformatf("rdata[%0d]", beat), rdata, rexp[beat]);
      checkOutput($sformatf("rlast[%0d]", beat), rlast, beat == int'(len));
      checkOutput($sformatf("rid[%0d]", beat), rid, id);
      checkOutput($sformatf("rresp[%0d]", beat), rresp, exp_resp);
      rready = rand_rready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rready) beat++;
      @(negedge aclk);
      n++;
    end
    rready = 1'b0;
    tmo |= (n >= 200);
    checkOutput("r_done", rvalid, 1'b0);
    checkOutput("arready_after_r", arready, 1'b1);
    checkOutput("rd_timeout", tmo, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("rst_awready", awready, 1'b0);
    checkOutput("rst_wready", wready, 1'b0);
    checkOutput("rst_bvalid", bvalid, 1'b0);
    checkOutput("rst_arready", arready, 1'b0);
    checkOutput("rst_rvalid", rvalid, 1'b0);
    checkOutput("rst_rlast", rlast, 1'b0);
    checkOutput("rst_bresp", bresp, 2'b00);
    checkOutput("rst_rresp", rresp, 2'b00);
    checkOutput("rst_bid", bid, 4'h0);
    checkOutput("rst_rid", rid, 4'h0);
    checkOutput("rst_rdata", rdata, '0);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("post_rst_awready", awready, 1'b1);
    checkOutput("post_rst_arready", arready, 1'b1);

    wd[0] = P0; wd[1] = P1; ws[0] = 16'hffff; ws[1] = 16'hffff;
    applyWrite(32'h100, 4'd1, 3'd4, INCR, 4'h1, OKAY, 0);

    wd[0] = 128'h00000000_00000000_00004739_00000000; ws[0] = 16'h00f0;
    wd[1] = 128'h00000000_00007163_00000000_00000000; ws[1] = 16'h0f00;
    wd[2] = 128'h0000A395_00000000_00000000_00000000; ws[2] = 16'hf000;
    wd[3] = 128'h00000000_00000000_00000000_00001507; ws[3] = 16'h000f;
    applyWrite(32'h104, 4'd3, 3'd2, INCR, 4'h5, OKAY, 10);
    rexp[0] = W10; rexp[1] = W10; rexp[2] = W10; rexp[3] = W11;
    rand_rready = 1'b1;
    applyRead(32'h104, 4'd3, 3'd2, INCR, 4'h6, OKAY);

    wd[0] = {4{32'hC0DE0000}}; ws[0] = 16'h00f0;
    wd[1] = {4{32'hC0DE0001}}; ws[1] = 16'h0f00;
    wd[2] = {4{32'hC0DE0002}}; ws[2] = 16'hf000;
    wd[3] = {4{32'hC0DE0003}}; ws[3] = 16'h000f;
    applyWrite(32'h704, 4'd3, 3'd2, WRAP, 4'h9, OKAY, 0);
    for (int i = 0; i < 4; i++) rexp[i] = WW;
    applyRead(32'h708, 4'd3, 3'd2, WRAP, 4'hA, OKAY);

    wd[0] = {16{8'h07}}; wd[1] = {16{8'h12}}; wd[2] = {16{8'h1D}};
    wd[3] = {16{8'h2E}}; wd[4] = {16{8'h39}};
    for (int i = 0; i < 5; i++) ws[i] = 16'h0040;
    applyWrite(32'h106, 4'd4, 3'd0, FIXED, 4'h3, OKAY, 0);
    for (int i = 0; i < 3; i++) rexp[i] = W10F;
    applyRead(32'h106, 4'd2, 3'd0, FIXED, 4'h4, OKAY);

    wd[0] = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004; ws[0] = 16'hffff;
    wd[1] = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004; ws[1] = 16'hffff;
    applyWrite(32'h200, 4'd1, 3'd7, INCR, 4'h2, OKAY, 0);
    rexp[0] = wd[0]; rexp[1] = wd[1];
    applyRead(32'h200, 4'd1, 3'd7, INCR, 4'h7, OKAY);

    wd[0] = 128'h11111111_22222222_33333333_44444444;
    wd[1] = 128'h55555555_66666666_77777777_88888888;
    applyWrite(32'h300, 4'd1, 3'd4, 2'b11, 4'hB, OKAY, 0);
    rexp[0] = wd[0]; rexp[1] = wd[1];
    applyRead(32'h300, 4'd1, 3'd4, INCR, 4'hC, OKAY);

    wd[0] = 128'h600DF00D_600DF00D_600DF00D_600DF00D;
    applyWrite(32'h0, 4'd0, 3'd4, INCR, 4'hD, OKAY, 0);
    wd[0] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
`ifdef AMBA3_AXI_SLAVE_MEM_SLVERR_EN
    applyWrite(32'h1000, 4'd0, 3'd4, INCR, 4'hE, SLVERR, 0);
    rexp[0] = 128'h600DF00D_600DF00D_600DF00D_600DF00D;
    applyRead(32'h0, 4'd0, 3'd4, INCR, 4'hF, OKAY);
    rexp[0] = '0;
    applyRead(32'h1000, 4'd0, 3'd4, INCR, 4'h8, SLVERR);
`else
    applyWrite(32'h1000, 4'd0, 3'd4, INCR, 4'hE, OKAY, 0);
    rexp[0] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    applyRead(32'h0, 4'd0, 3'd4, INCR, 4'hF, OKAY);
`endif

    awid = 4'h1; awaddr = 32'h400; awlen = 4'd3; awsize = 3'd4; awburst = INCR; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    wdata = '1; wstrb = '1; wvalid = 1'b1;
    @(negedge aclk);
    checkOutput("midburst_wready", wready, 1'b1);
    areset = 1'b1;
    #1;
    checkOutput("midrst_wready", wready, 1'b0);
    checkOutput("midrst_awready", awready, 1'b0);
    checkOutput("midrst_bvalid", bvalid, 1'b0);
    wvalid = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("after_midrst_awready", awready, 1'b1);
    checkOutput("after_midrst_arready", arready, 1'b1);
    checkOutput("after_midrst_bvalid", bvalid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/amba3_axi_slave_mem.md
AMBA3_AXI_SLAVE_MEM -- requirements
Module: amba3_axi_slave_mem

Interface
REQ-001 SHALL have parameter TXID_SIZE, default 4, ID width.
REQ-002 SHALL have parameter ADDR_SIZE, default 32, address width.
REQ-003 SHALL have parameter DATA_SIZE, default 128, data width; legal values 32, 64, 128.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, number of DATA_SIZE-bit memory words; power of two.
REQ-005 SHALL have port aclk, input, 1, clock; one clock, all logic on rising edge.
REQ-006 SHALL have port areset, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have AW ports: awid TXID_SIZE, awaddr ADDR_SIZE, awlen 4, awsize 3, awburst 2, awvalid 1 (inputs); awready 1 (output).
REQ-008 SHALL have W ports: wid TXID_SIZE, wdata DATA_SIZE, wstrb DATA_SIZE/8, wlast 1, wvalid 1 (inputs); wready 1 (output).
REQ-009 SHALL have B ports: bid TXID_SIZE, bresp 2, bvalid 1 (outputs); bready 1 (input).
REQ-010 SHALL have AR ports: arid, araddr, arlen, arsize, arburst, arvalid (inputs, widths as AW); arready 1 (output).
REQ-011 SHALL have R ports: rid TXID_SIZE, rdata DATA_SIZE, rresp 2, rlast 1, rvalid 1 (outputs); rready 1 (input).

Function
REQ-012 SHALL run independent write and read FSMs, one outstanding transaction each, no reordering.
REQ-013 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-014 AW handshake SHALL latch id/addr/len/size/burst and move to W_DATA next cycle.
REQ-015 Each W handshake SHALL write the bytes enabled by wstrb into the word at the current address; disabled bytes unchanged; wid ignored.
REQ-016 Beat count SHALL govern burst end: after beat awlen+1 move to W_RESP; wlast not used for termination.
REQ-017 W_RESP SHALL drive bid=latched awid and bresp; hold stable until bready; go W_IDLE the cycle after bvalid&&bready.
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake latches fields, rvalid=1 the next cycle.
REQ-019 In R_DATA rdata SHALL equal the full memory word at the current address, rid=latched arid, rlast=1 on beat arlen+1 only; all R outputs stable while rvalid&&!rready.
REQ-020 After the rlast handshake the read FSM SHALL return to R_IDLE; arready=1 the following cycle.
REQ-021 Next address: FIXED (2'b00) unchanged; INCR (2'b01) size-aligned address + 2^size; WRAP (2'b10) same, wrapped within aligned (len+1)*2^size window; reserved 2'b11 treated as INCR.
REQ-022 awsize/arsize above log2(DATA_SIZE/8) SHALL be clamped to log2(DATA_SIZE/8).
REQ-023 Word index SHALL be addr[ADDR_SIZE-1 : log2(DATA_SIZE/8)] modulo MEM_DEPTH.
REQ-024 Same-cycle read and write of one word: read SHALL return pre-write data; write commits at that edge.

Reset
REQ-025 During reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0; FSMs in W_IDLE/R_IDLE.
REQ-026 First cycle after reset release awready=1 and arready=1.
REQ-027 Reset mid-burst SHALL abandon the transaction, with no B or R response; memory contents not reset and not guaranteed.

Configuration
REQ-028 Macro AMBA3_AXI_SLAVE_MEM_SLVERR_EN defined: any beat whose word index is >= MEM_DEPTH SHALL not write, return rdata=0, and give SLVERR (2'b10) on that R beat, or on B if any write beat was out of range.
REQ-029 Macro undefined: index wraps modulo MEM_DEPTH and bresp/rresp are always OKAY (2'b00).

Structure
REQ-030 Package pkg_amba3 SHALL hold burst enum (FIXED/INCR/WRAP), resp enum (OKAY/EXOKAY/SLVERR/DECERR) and the next-address function.
REQ-031 Sub-module amba3_axi_burst_addr (combinational next address from addr/len/size/burst) SHALL be instanced twice, once for write and once for read.

Verification
REQ-032 INCR write awaddr 0x104, size 2, len 3, wdata beats 0x4739<<32, 0x7163<<64, 0xA395<<96, 0x1507, wstrb 0x00f0/0x0f00/0xf000/0x000f -> bresp OKAY; INCR read of the same burst returns the same words with rlast on beat 4 only.
REQ-033 WRAP write 0x704, size 2, len 3 -> fourth beat lands in word 0x700; read at 0x708 returns the beat order 2,3,0,1 of that data.
REQ-034 FIXED write 0x106, size 0, len 4, strobe 0x0040, bytes 0x07..0x39 -> read gives byte 6 = 0x39 and the other bytes unchanged.
REQ-035 bready held low 10 cycles, rready toggled randomly -> bvalid/bid/bresp and rdata/rlast stable while stalled; awready stays 0 until B completes.
REQ-036 With SLVERR_EN, MEM_DEPTH 256, DATA_SIZE 128: write to 0x1000 -> bresp 2'b10 and no word corrupted; without the macro the write aliases to word 0.
